// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared sizing constants for the instruction memory
package inst_mem_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_LANES  = IMEM_DATA_W / 8;
  localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;

endpackage

// File: rtl/imem_lane_addr.sv
// rtl/imem_lane_addr.sv - maps a base byte address to its wrapped per-lane byte addresses
module imem_lane_addr
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int LANES  = IMEM_LANES
) (
  input  logic [ADDR_W-1:0]             base,
  output logic [LANES-1:0][ADDR_W-1:0]  lane_a
);

  // lane j sits at base+j; the ADDR_W-bit add wraps modulo the memory depth
  always_comb begin
    lane_a = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_a[j] = base + ADDR_W'(j);
    end
  end

endmodule

// File: rtl/inst_memory.sv
// rtl/inst_memory.sv - byte-addressable instruction memory with word write and combinational word read
module inst_memory
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memW,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  // byte storage; the async clear keeps this as registers rather than a RAM macro
  logic [7:0] mem [DEPTH];

  logic [LANES-1:0][ADDR_W-1:0] lane_a;

  // address bits above ADDR_W alias onto the low range and are deliberately dropped
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_W];

  // one lane-address decoder shared by the read and write paths
  imem_lane_addr #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_lane_addr (
    .base   (address[ADDR_W-1:0]),
    .lane_a (lane_a)
  );

  // reset clears every byte immediately; otherwise a write updates all lanes together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (memW) begin
      for (int j = 0; j < LANES; j++) begin
        mem[lane_a[j]] <= Din[8*j +: 8];
      end
    end
  end

  // zero-latency little-endian read, no bypass of a pending write
  always_comb begin
    Dout = '0;
    for (int j = 0; j < LANES; j++) begin
      Dout[8*j +: 8] = mem[lane_a[j]];
    end
  end

endmodule

// File: tb/tb_inst_memory.sv
// tb/tb_inst_memory.sv - randomized self-checking bench for inst_memory against a byte-array model
module tb_inst_memory;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_n = 1'b1;
  logic        memW = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  byte unsigned model [1024];

  inst_memory dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .memW    (memW),
    .address (address),
    .Din     (Din),
    .Dout    (Dout)
  );

  // gated clock so reset can be exercised with no edges at all
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int a;
    logic [31:0] r;
    a = int'(addr % 1024);
    r = '0;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = model[(a + j) % 1024];
    return r;
  endfunction

  // model: async clear on reset assertion
  always @(negedge rst_n) begin
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
  end

  // model: word write on a clock edge when out of reset
  always @(posedge clk) begin
    if (rst_n === 1'b1 && memW === 1'b1) begin
      for (int j = 0; j < 4; j++) model[(int'(address % 1024) + j) % 1024] = Din[8*j +: 8];
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (Dout !== model_read(address)) begin
        n_bad++;
        $display("FAIL model_cmp addr=%08h got=%08h want=%08h", address, Dout, model_read(address));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] want);
    n_cmp++;
    if (Dout !== want) begin
      n_bad++;
      $display("FAIL %s addr=%08h got=%08h want=%08h", name, address, Dout, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string name, input logic [31:0] addr, input logic [31:0] want);
    address = addr;
    #1;
    check(name, want);
  endtask

  task automatic random_run(input int n, input bit wide_addr);
    for (int k = 0; k < n; k++) begin
      memW    = ($urandom_range(0, 2) != 0);
      address = wide_addr ? $urandom() : 32'($urandom_range(0, 1023));
      Din     = $urandom();
      cyc();
    end
    memW = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    peek("rst_addr0", 32'd0, 32'h0);
    peek("rst_addr1020", 32'd1020, 32'h0);
    repeat (3) cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();
    peek("post_rst_unwritten", 32'd512, 32'h0);

    random_run(200, 1'b0);

    // reset mid-run with the clock stopped
    @(negedge clk);
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    peek("midrst_addr0", 32'd0, 32'h0);
    peek("midrst_addr4", 32'd4, 32'h0);
    peek("midrst_addr1020", 32'd1020, 32'h0);
    rst_n = 1'b1;
    #2 clk_en = 1'b1;
    cyc();

    // aligned fill
    memW = 1'b1;
    for (int i = 0; i < 1024; i += 4) begin
      address = 32'(i);
      Din = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
      cyc();
    end
    memW = 1'b0;
    peek("fill_addr0", 32'd0, 32'h03020100);
    peek("fill_addr8", 32'd8, 32'h0B0A0908);
    peek("fill_addr1020", 32'd1020, 32'hFFFEFDFC);
    peek("unal_addr1", 32'd1, 32'h04030201);
    peek("unal_addr3", 32'd3, 32'h06050403);
    peek("unal_wrap1022", 32'd1022, 32'h0100FFFE);
    peek("alias_400", 32'h400, 32'h03020100);
    peek("alias_high", 32'hFFFF_FC08, 32'h0B0A0908);

    // write/read timing at address 16
    cyc();
    address = 32'd16;
    Din = 32'hDEADBEEF;
    memW = 1'b1;
    #1;
    check("wr_before_edge", 32'h13121110);
    cyc();
    check("wr_after_edge", 32'hDEADBEEF);
    memW = 1'b0;

    // disabled write with changing data leaves contents alone
    address = 32'd0;
    for (int k = 0; k < 4; k++) begin
      Din = $urandom();
      cyc();
    end
    check("memw0_hold", 32'h03020100);
    peek("memw0_hold16", 32'd16, 32'hDEADBEEF);

    // reset asserted across a write edge: reset wins
    address = 32'd100;
    Din = 32'hCAFEF00D;
    memW = 1'b1;
    rst_n = 1'b0;
    cyc();
    memW = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_beats_write", 32'h0);
    cyc();

    random_run(300, 1'b1);
    random_run(100, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
